// File: rtl/seg_scan_if.sv
// Bus bundle between a display client and the seven-segment scan controller.
// The master supplies the frame value and display options; the slave returns
// the handshake status and the per-digit drive signals.
interface seg_scan_if #(
    parameter int NDIG = 8
);
    logic [4*NDIG-1:0] value;
    logic              load;
    logic              ready;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   digit_en;
    logic              lz_blank;
    logic [3:0]        x;
    logic [NDIG-1:0]   an;
    logic              dp_n;
    logic [2:0]        digit_idx;

    modport master (
        output value, load, dp_in, digit_en, lz_blank,
        input  ready, x, an, dp_n, digit_idx
    );

    modport slave (
        input  value, load, dp_in, digit_en, lz_blank,
        output ready, x, an, dp_n, digit_idx
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// One digit is lit at a time, separated by an all-dark gap so the previous
// digit's segments never ghost onto the next anode. New values are staged in
// a pending buffer and only promoted at the end of a full frame, so a frame is
// always drawn from a single consistent value.
module seg_scan_ctrl #(
    parameter int NDIG        = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]    LAST_IDX     = 3'(NDIG - 1);

    typedef enum logic [0:0] {
        GAP  = 1'b0,
        SCAN = 1'b1
    } scanState_t;

    scanState_t         r_state,      w_state;
    logic [CW-1:0]      r_cnt,        w_cnt;
    logic [2:0]         r_idx,        w_idx;
    logic [NDIG-1:0]    r_an,         w_an;
    logic               r_dpN,        w_dpN;
    logic [3:0]         r_x,          w_x;
    logic               r_ready,      w_ready;

    logic [4*NDIG-1:0]  r_pendValue,  w_pendValue;
    logic [NDIG-1:0]    r_pendDp,     w_pendDp;
    logic [NDIG-1:0]    r_pendEn,     w_pendEn;
    logic               r_pendLz,     w_pendLz;

    logic [4*NDIG-1:0]  r_actValue,   w_actValue;
    logic [NDIG-1:0]    r_actDp,      w_actDp;
    logic [NDIG-1:0]    r_actEn,      w_actEn;
    logic               r_actLz,      w_actLz;

    logic [3:0]         w_nib;
    logic               w_digEn;
    logic               w_digDp;
    logic [2:0]         w_hiNonZero;
    logic               w_visible;
    logic [NDIG-1:0]    w_scanAn;

    // Per-digit view of the active buffer for the currently selected digit,
    // including leading-zero suppression and the anode pattern it would drive.
    always_comb begin
        w_nib       = 4'd0;
        w_digEn     = 1'b0;
        w_digDp     = 1'b0;
        w_hiNonZero = 3'd0;
        w_scanAn    = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_actValue[4*i +: 4] != 4'd0) begin
                w_hiNonZero = 3'(i);
            end
            if (r_idx == 3'(i)) begin
                w_nib   = r_actValue[4*i +: 4];
                w_digEn = r_actEn[i];
                w_digDp = r_actDp[i];
            end
        end
        w_visible = w_digEn && !(r_actLz && (r_idx != 3'd0) && (r_idx > w_hiNonZero));
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == 3'(i)) begin
                w_scanAn[i] = ~w_visible;
            end
        end
    end

    // Next-state logic: gap/scan sequencing, digit stepping, frame-boundary
    // promotion of the pending buffer and the load handshake.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt + CW'(1);
        w_idx       = r_idx;
        w_an        = r_an;
        w_dpN       = r_dpN;
        w_x         = r_x;
        w_ready     = r_ready;
        w_pendValue = r_pendValue;
        w_pendDp    = r_pendDp;
        w_pendEn    = r_pendEn;
        w_pendLz    = r_pendLz;
        w_actValue  = r_actValue;
        w_actDp     = r_actDp;
        w_actEn     = r_actEn;
        w_actLz     = r_actLz;

        case (r_state)
            GAP: begin
                w_an  = '1;
                w_dpN = 1'b1;
                w_x   = w_nib;
                if (r_cnt == BLANK_LAST) begin
                    w_cnt   = '0;
                    w_state = SCAN;
                    w_an    = w_scanAn;
                    w_dpN   = ~(w_digDp && w_visible);
                end
            end
            SCAN: begin
                if (r_cnt == REFRESH_LAST) begin
                    w_cnt   = '0;
                    w_state = GAP;
                    w_an    = '1;
                    w_dpN   = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx = 3'd0;
                        if (!r_ready) begin
                            w_actValue = r_pendValue;
                            w_actDp    = r_pendDp;
                            w_actEn    = r_pendEn;
                            w_actLz    = r_pendLz;
                            w_ready    = 1'b1;
                        end
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state = GAP;
                w_cnt   = '0;
            end
        endcase

        if (bus.load && r_ready) begin
            w_pendValue = bus.value;
            w_pendDp    = bus.dp_in;
            w_pendEn    = bus.digit_en;
            w_pendLz    = bus.lz_blank;
            w_ready     = 1'b0;
        end
    end

    // State register; reset aborts any scan and discards a pending update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= GAP;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_an        <= '1;
            r_dpN       <= 1'b1;
            r_x         <= 4'd0;
            r_ready     <= 1'b1;
            r_pendValue <= '0;
            r_pendDp    <= '0;
            r_pendEn    <= '0;
            r_pendLz    <= 1'b0;
            r_actValue  <= '0;
            r_actDp     <= '0;
            r_actEn     <= '1;
            r_actLz     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_an        <= w_an;
            r_dpN       <= w_dpN;
            r_x         <= w_x;
            r_ready     <= w_ready;
            r_pendValue <= w_pendValue;
            r_pendDp    <= w_pendDp;
            r_pendEn    <= w_pendEn;
            r_pendLz    <= w_pendLz;
            r_actValue  <= w_actValue;
            r_actDp     <= w_actDp;
            r_actEn     <= w_actEn;
            r_actLz     <= w_actLz;
        end
    end

    assign bus.ready     = r_ready;
    assign bus.x         = r_x;
    assign bus.an        = r_an;
    assign bus.dp_n      = r_dpN;
    assign bus.digit_idx = r_idx;

endmodule
